tx_sched: RTL and testbench

- Parametrised multi-channel transmit scheduler between the measurement engines (N_CH result channels) and the serial TX framer.
- Decodes host commands to select a channel and a mode: config echo, single-shot or continuous.
- Holds one result frame and presents it on a valid/ready interface, tagged with its channel index.
- Successor to the fixed two-source TX FSM: adds channel count, handshake, overrun detection and command back-pressure.

---
 rtl/tx_sched_pkg.sv | 29 ++
 rtl/tx_sched_hold_reg.sv | 49 ++++
 rtl/tx_sched.sv | 206 ++++++++++++++++++++
 tb/tb_tx_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the multi-channel transmit scheduler: command op codes,
// FSM state encodings, overrun counter width and a saturating-increment helper.
package tx_sched_pkg;

  localparam int OVR_W = 8;

  typedef enum logic [1:0] {
    OP_STOP   = 2'b00,
    OP_SINGLE = 2'b01,
    OP_CONT   = 2'b10,
    OP_CFG    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CONFIG = 2'b01,
    ST_SINGLE = 2'b10,
    ST_CONT   = 2'b11
  } state_t;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    if (v == {OVR_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + OVR_W'(1);
    end
  endfunction

endpackage

// File: rtl/tx_sched_hold_reg.sv
// One-slot frame hold register with valid/ready output handshake; flags a load
// that lands on a frame the framer has not yet taken (overwrite).
module tx_hold_reg #(
  parameter int SIZE = 32,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [SIZE-1:0] load_data,
  input  logic [CH_W-1:0] load_ch,
  input  logic            ready,
  output logic            valid,
  output logic [SIZE-1:0] data,
  output logic [CH_W-1:0] ch,
  output logic            ovr
);

  logic            valid_r;
  logic [SIZE-1:0] data_r;
  logic [CH_W-1:0] ch_r;

  // Slot state: clear wins, then a new load (which also covers load-during-transfer), then handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      data_r  <= {SIZE{1'b0}};
      ch_r    <= {CH_W{1'b0}};
    end else if (clr) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      ch_r    <= load_ch;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign ch    = ch_r;
  // A load while the framer accepts the old frame is a clean hand-over, not an overwrite.
  assign ovr   = load & valid_r & ~ready;

endmodule

// File: rtl/tx_sched.sv
// Multi-channel transmit scheduler: host command decode, channel select, and one
// held result frame on valid/ready. Define OVERRUN_CNT_EN to enable the overrun counter.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int CH_W = 2,
  parameter int N_CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 control,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CH_W+1:0]      cmd,
  input  logic [SIZE-1:0]      cfg_data,
  input  logic [N_CH-1:0]      ch_valid,
  input  logic [N_CH*SIZE-1:0] ch_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [SIZE-1:0]      tx_data,
  output logic [CH_W-1:0]      tx_ch,
  output logic                 err,
  output logic [OVR_W-1:0]     ovr_cnt
);

  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  state_t          state_r, state_n;
  logic [CH_W-1:0] sel_r, sel_n;
  logic            pend_r, pend_n;
  logic            armed_r, armed_n;
  logic            err_r, err_n;

  op_t             op_s;
  logic [CH_W-1:0] ch_s;
  logic            ch_ok_s;
  logic            cmd_acc_s;
  logic            sel_valid_s;
  logic [SIZE-1:0] sel_data_s;
  logic            load_s;
  logic [SIZE-1:0] load_data_s;
  logic [CH_W-1:0] load_ch_s;
  logic            clr_s;
  logic            ovr_s;
  logic            ovr_clr_s;

  assign op_s      = op_t'(cmd[CH_W+1:CH_W]);
  assign ch_s      = cmd[CH_W-1:0];
  assign ch_ok_s   = ({1'b0, ch_s} < N_CH_L);
  assign cmd_ready = ~tx_valid;
  assign cmd_acc_s = cmd_valid & cmd_ready;

  // Select strobe and payload of the latched channel.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = {SIZE{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      sel_valid_s = sel_valid_s | (ch_valid[k] & (sel_r == CH_W'(k)));
      sel_data_s  = sel_data_s | (ch_data[k*SIZE +: SIZE] & {SIZE{sel_r == CH_W'(k)}});
    end
  end

  // Next-state and hold-register control; control low beats commands, commands beat capture.
  always_comb begin
    state_n     = state_r;
    sel_n       = sel_r;
    pend_n      = 1'b0;
    armed_n     = armed_r;
    err_n       = 1'b0;
    load_s      = 1'b0;
    load_data_s = sel_data_s;
    load_ch_s   = sel_r;
    clr_s       = 1'b0;
    ovr_clr_s   = 1'b0;
    if (!control) begin
      state_n = ST_IDLE;
      clr_s   = 1'b1;
      armed_n = 1'b0;
    end else if (cmd_acc_s) begin
      if (state_r == ST_IDLE) begin
        if (op_s == OP_CFG) begin
          state_n   = ST_CONFIG;
          pend_n    = 1'b1;
          ovr_clr_s = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end else begin
        case (op_s)
          OP_STOP: begin
            state_n = ST_IDLE;
            armed_n = 1'b0;
          end
          OP_CFG: begin
            state_n   = ST_CONFIG;
            pend_n    = 1'b1;
            armed_n   = 1'b0;
            ovr_clr_s = 1'b1;
          end
          OP_SINGLE, OP_CONT: begin
            if (ch_ok_s) begin
              state_n = (op_s == OP_SINGLE) ? ST_SINGLE : ST_CONT;
              sel_n   = ch_s;
              armed_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          default: begin
            state_n = state_r;
          end
        endcase
      end
    end else begin
      case (state_r)
        ST_CONFIG: begin
          if (pend_r) begin
            load_s      = 1'b1;
            load_data_s = cfg_data;
            load_ch_s   = {CH_W{1'b0}};
          end else begin
            load_s = 1'b0;
          end
        end
        ST_SINGLE: begin
          if (armed_r && sel_valid_s) begin
            load_s  = 1'b1;
            armed_n = 1'b0;
          end else if (!armed_r && tx_valid && tx_ready) begin
            state_n   = ST_CONFIG;
            ovr_clr_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        ST_CONT: begin
          load_s = sel_valid_s;
        end
        default: begin
          load_s = 1'b0;
        end
      endcase
    end
  end

  // FSM and command-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      sel_r   <= {CH_W{1'b0}};
      pend_r  <= 1'b0;
      armed_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      sel_r   <= sel_n;
      pend_r  <= pend_n;
      armed_r <= armed_n;
      err_r   <= err_n;
    end
  end

  assign err = err_r;

  tx_hold_reg #(
    .SIZE (SIZE),
    .CH_W (CH_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .load      (load_s),
    .load_data (load_data_s),
    .load_ch   (load_ch_s),
    .ready     (tx_ready),
    .valid     (tx_valid),
    .data      (tx_data),
    .ch        (tx_ch),
    .ovr       (ovr_s)
  );

`ifdef OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_cnt_r;

  // Saturating overwrite counter, restarted whenever CONFIG is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_cnt_r <= {OVR_W{1'b0}};
    end else if (ovr_clr_s) begin
      ovr_cnt_r <= {OVR_W{1'b0}};
    end else if (ovr_s) begin
      ovr_cnt_r <= sat_inc(ovr_cnt_r);
    end else begin
      ovr_cnt_r <= ovr_cnt_r;
    end
  end

  assign ovr_cnt = ovr_cnt_r;
`else
  logic unused_ovr_s;
  assign unused_ovr_s = ovr_s ^ ovr_clr_s;
  assign ovr_cnt      = {OVR_W{1'b0}};
`endif

endmodule

// File: tb/tb_tx_sched.sv
// Directed self-checking bench for tx_sched (N_CH=3 so an out-of-range channel exists).
module tb_tx_sched;

  localparam int SIZE = 32;
  localparam int CH_W = 2;
  localparam int N_CH = 3;
`ifdef OVERRUN_CNT_EN
  localparam logic [7:0] OVR_EXP = 8'd2;
`else
  localparam logic [7:0] OVR_EXP = 8'd0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 control;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CH_W+1:0]      cmd;
  logic [SIZE-1:0]      cfg_data;
  logic [N_CH-1:0]      ch_valid;
  logic [N_CH*SIZE-1:0] ch_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [SIZE-1:0]      tx_data;
  logic [CH_W-1:0]      tx_ch;
  logic                 err;
  logic [7:0]           ovr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  tx_sched #(.SIZE(SIZE), .CH_W(CH_W), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .control(control), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cfg_data(cfg_data), .ch_valid(ch_valid), .ch_data(ch_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_ch(tx_ch),
    .err(err), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch);
    cmd       = {op, ch};
    cmd_valid = 1'b1;
  endtask

  task automatic strobe(input int k, input logic [31:0] v);
    ch_valid             = '0;
    ch_valid[k]          = 1'b1;
    ch_data[k*SIZE +: SIZE] = v;
  endtask

  initial begin
    rst = 1'b0; control = 1'b0; cmd_valid = 1'b0; cmd = '0; cfg_data = '0;
    ch_valid = '0; ch_data = '0; tx_ready = 1'b0;
    step(); step();
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_tx_data", tx_data, 32'd0);
    check_eq("rst_ovr_cnt", {24'd0, ovr_cnt}, 32'd0);

    // 1: config frame, exactly one cycle with tx_ready high
    rst = 1'b1; control = 1'b1; tx_ready = 1'b1; cfg_data = 32'h0000_1234;
    send_cmd(2'b11, 2'd0);
    step(); cmd_valid = 1'b0;
    check_eq("cfg_latency", {31'd0, tx_valid}, 32'd0);
    step();
    check_eq("cfg_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("cfg_data", tx_data, 32'h0000_1234);
    check_eq("cfg_ch", {30'd0, tx_ch}, 32'd0);
    check_eq("cfg_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    check_eq("cfg_one_cycle", {31'd0, tx_valid}, 32'd0);
    step();
    check_eq("cfg_no_repeat", {31'd0, tx_valid}, 32'd0);

    // 2: single shot on ch 2, second strobe ignored, back to CONFIG
    send_cmd(2'b01, 2'd2);
    step(); cmd_valid = 1'b0; tx_ready = 1'b0; strobe(2, 32'hAA);
    step(); strobe(2, 32'hBB);
    check_eq("single_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("single_data", tx_data, 32'hAA);
    check_eq("single_ch", {30'd0, tx_ch}, 32'd2);
    step(); ch_valid = '0; tx_ready = 1'b1;
    check_eq("single_2nd_ignored", tx_data, 32'hAA);
    step(); strobe(2, 32'hCC);
    check_eq("single_done", {31'd0, tx_valid}, 32'd0);
    step(); ch_valid = '0;
    check_eq("config_no_capture", {31'd0, tx_valid}, 32'd0);

    // 4a: illegal channel -> one-cycle err pulse, stays in CONFIG
    send_cmd(2'b01, 2'd3);
    step(); cmd_valid = 1'b0;
    check_eq("err_pulse", {31'd0, err}, 32'd1);
    step(); ch_valid = 3'b111;
    check_eq("err_clear", {31'd0, err}, 32'd0);
    step(); ch_valid = '0;
    check_eq("err_state_config", {31'd0, tx_valid}, 32'd0);

    // 4b: command back-pressure while a frame is pending
    tx_ready = 1'b0; cfg_data = 32'h0000_5678;
    send_cmd(2'b11, 2'd0);
    step(); cmd_valid = 1'b0;
    step();
    check_eq("cfg2_data", tx_data, 32'h0000_5678);
    send_cmd(2'b10, 2'd1);
    check_eq("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    step();
    check_eq("bp_hold_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("bp_hold_data", tx_data, 32'h0000_5678);
    tx_ready = 1'b1;
    step();
    check_eq("bp_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);
    check_eq("bp_frame_done", {31'd0, tx_valid}, 32'd0);

    // 3: continuous mode with overruns
    step(); cmd_valid = 1'b0; tx_ready = 1'b0; strobe(1, 32'd1);
    step(); strobe(1, 32'd2);
    check_eq("cont_first", tx_data, 32'd1);
    step(); strobe(1, 32'd3);
    check_eq("cont_overwrite", tx_data, 32'd2);
    step(); ch_valid = '0;
    check_eq("cont_last", tx_data, 32'd3);
    check_eq("cont_ch", {30'd0, tx_ch}, 32'd1);
    check_eq("ovr_cnt", {24'd0, ovr_cnt}, {24'd0, OVR_EXP});
    tx_ready = 1'b1;
    step();
    check_eq("cont_single_frame", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0; strobe(1, 32'd4);
    step(); tx_ready = 1'b1; strobe(1, 32'd5);
    step(); ch_valid = '0; tx_ready = 1'b0;
    check_eq("xfer_capture_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("xfer_capture_data", tx_data, 32'd5);
    check_eq("xfer_not_overrun", {24'd0, ovr_cnt}, {24'd0, OVR_EXP});

    // 5: control drop clears pending frame; non-CFG commands ignored in IDLE
    control = 1'b0;
    step();
    check_eq("ctl_drop_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("ctl_drop_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    control = 1'b1; send_cmd(2'b01, 2'd1);
    step(); cmd_valid = 1'b0; strobe(1, 32'h77);
    step(); ch_valid = '0;
    check_eq("idle_ignore_cmd", {31'd0, tx_valid}, 32'd0);
    check_eq("idle_no_err", {31'd0, err}, 32'd0);
    cfg_data = 32'h0000_9ABC; send_cmd(2'b11, 2'd0);
    step(); cmd_valid = 1'b0;
    step();
    check_eq("idle_cfg_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("idle_cfg_data", tx_data, 32'h0000_9ABC);

    // 6: asynchronous reset with a frame pending
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("async_rst_data", tx_data, 32'd0);
    check_eq("async_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step(); rst = 1'b1;
    step();
    check_eq("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("post_rst_valid", {31'd0, tx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
